// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths, opcode names, arbiter states
// and the opcode-class helpers used when sanitising ALU flags.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_MUL  = 5'd4,
    OP_NEG  = 5'd5,
    OP_DIV  = 5'd6,
    OP_DIVU = 5'd7,
    OP_MOD  = 5'd8,
    OP_XOR  = 5'd9,
    OP_NOT  = 5'd10,
    OP_NAND = 5'd11,
    OP_NOR  = 5'd12,
    OP_XNOR = 5'd13,
    OP_SLT  = 5'd14,
    OP_SLTU = 5'd15,
    OP_SHR  = 5'd16,
    OP_SHL  = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_e;

  function automatic logic isOvfOp(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_NEG};
  endfunction

  function automatic logic isDivOp(input logic [OP_W-1:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_MOD};
  endfunction

  // Everything above the last defined opcode is illegal.
  function automatic logic isIllegalOp(input logic [OP_W-1:0] op);
    return op > OP_SHL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant for the first requester at or after ptr,
// wrapping at N_REQ. Purely combinational.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one combinational ALU among N_REQ requesters: round-robin accept, one
// operation in flight, sanitised result held until the consumer takes it.
//   state   | meaning
//   ST_IDLE | offering reqReady to the round-robin winner
//   ST_EXEC | ALU settling on latched operands; result captured at cycle end
//   ST_RESP | response held until rspReady
module alu_request_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          reqValid,
  output logic [N_REQ-1:0]          reqReady,
  input  logic [N_REQ*OP_W-1:0]     reqOpCode,
  input  logic [N_REQ*DATA_W-1:0]   reqDataA,
  input  logic [N_REQ*DATA_W-1:0]   reqDataB,
  output logic [OP_W-1:0]           aluOpCode,
  output logic [DATA_W-1:0]         aluDataA,
  output logic [DATA_W-1:0]         aluDataB,
  input  logic [DATA_W-1:0]         aluDataC,
  input  logic                      aluZero,
  input  logic                      aluOverflow,
  input  logic                      aluError,
  output logic                      rspValid,
  input  logic                      rspReady,
  output logic [ID_W-1:0]           rspId,
  output logic [DATA_W-1:0]         rspDataC,
  output logic                      rspZero,
  output logic                      rspOverflow,
  output logic                      rspError
);

  import alu_pkg::*;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_vld;
  logic              san_ovf;
  logic              san_err;
  logic [DATA_W-1:0] san_data;
  logic              unused_alu_flags;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (reqValid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  // ALU zero/error are not trusted: zero is recomputed and error derived from the opcode.
  assign unused_alu_flags = aluZero ^ aluError;

  assign san_ovf  = isOvfOp(op_q) & aluOverflow;
  assign san_err  = isIllegalOp(op_q) | (isDivOp(op_q) & (b_q == '0));
  assign san_data = san_err ? '0 : aluDataC;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
              op_d = reqOpCode[i*OP_W +: OP_W];
              a_d  = reqDataA[i*DATA_W +: DATA_W];
              b_d  = reqDataB[i*DATA_W +: DATA_W];
              id_d = ID_W'(i);
            end
          end
          rr_ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_id_d   = id_q;
        rsp_data_d = san_data;
        rsp_zero_d = (san_data == '0);
        rsp_ovf_d  = san_ovf;
        rsp_err_d  = san_err;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Ready is masked by reset so nothing looks accepted while reset is held.
  assign reqReady    = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign aluOpCode   = op_q;
  assign aluDataA    = a_q;
  assign aluDataB    = b_q;
  assign rspValid    = (state_q == ST_RESP);
  assign rspId       = rsp_id_q;
  assign rspDataC    = rsp_data_q;
  assign rspZero     = rsp_zero_q;
  assign rspOverflow = rsp_ovf_q;
  assign rspError    = rsp_err_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Scoreboard bench: stimulus predicts grants and responses from the arbitration
// and sanitising rules; a separate monitor pops and compares each response.
module tb_alu_request_arbiter;
  import alu_pkg::*;

  localparam int N  = 3;
  localparam int IW = 2;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              ovf;
  } item_t;

  typedef struct packed {
    logic [IW-1:0]     id;
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              ovf;
    logic              err;
  } rsp_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          reqValid;
  logic [N-1:0]          reqReady;
  logic [N*OP_W-1:0]     reqOpCode;
  logic [N*DATA_W-1:0]   reqDataA;
  logic [N*DATA_W-1:0]   reqDataB;
  logic [OP_W-1:0]       aluOpCode;
  logic [DATA_W-1:0]     aluDataA;
  logic [DATA_W-1:0]     aluDataB;
  logic [DATA_W-1:0]     aluDataC;
  logic                  aluZero;
  logic                  aluOverflow;
  logic                  aluError;
  logic                  rspValid;
  logic                  rspReady;
  logic [IW-1:0]         rspId;
  logic [DATA_W-1:0]     rspDataC;
  logic                  rspZero;
  logic                  rspOverflow;
  logic                  rspError;

  int    n_tests;
  int    n_fail;
  item_t pend [N][$];
  rsp_t  sb_q [$];
  int    m_ptr;
  bit    m_free;
  int    m_wait;
  int    vpct;
  int    rpct;
  logic  ovf_knob;

  always #5 clock = ~clock;

  alu_request_arbiter #(.N_REQ(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqOpCode   (reqOpCode),
    .reqDataA    (reqDataA),
    .reqDataB    (reqDataB),
    .aluOpCode   (aluOpCode),
    .aluDataA    (aluDataA),
    .aluDataB    (aluDataB),
    .aluDataC    (aluDataC),
    .aluZero     (aluZero),
    .aluOverflow (aluOverflow),
    .aluError    (aluError),
    .rspValid    (rspValid),
    .rspReady    (rspReady),
    .rspId       (rspId),
    .rspDataC    (rspDataC),
    .rspZero     (rspZero),
    .rspOverflow (rspOverflow),
    .rspError    (rspError)
  );

  // Behavioural ALU; deliberately returns junk for divide-by-zero and illegal ops.
  function automatic logic [DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_MUL:  return a * b;
      OP_NEG:  return -a;
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_MOD:  return (b == 0) ? 32'h1234_5678 : a % b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'b0, a < b};
      OP_SHR:  return a >> sh;
      OP_SHL:  return a << sh;
      default: return 32'hDEAD_BEEF ^ a;
    endcase
  endfunction

  always_comb aluDataC = alu_ref(aluOpCode, aluDataA, aluDataB);
  assign aluZero     = (aluDataC == 0);
  assign aluOverflow = ovf_knob;
  assign aluError    = (aluOpCode >= 5'd18);

  function automatic rsp_t ref_rsp(input int id, input item_t it);
    rsp_t r;
    int   op;
    op     = int'(it.op);
    r.id   = IW'(id);
    r.err  = ((op == 6 || op == 7 || op == 8) && it.b == 0) || (op >= 18);
    r.ovf  = (op == 0 || op == 1 || op == 4 || op == 5) && it.ovf;
    r.data = r.err ? '0 : alu_ref(it.op, it.a, it.b);
    r.zero = (r.data == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic ovf);
    item_t it;
    it.op = op; it.a = a; it.b = b; it.ovf = ovf;
    pend[r].push_back(it);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] eg;
    item_t        h;
    int           gi;
    for (int i = 0; i < N; i++) begin
      v[i] = (pend[i].size() > 0) && ($urandom_range(0, 99) < vpct);
      if (v[i]) begin
        h = pend[i][0];
        reqOpCode[i*OP_W +: OP_W]     = h.op;
        reqDataA[i*DATA_W +: DATA_W]  = h.a;
        reqDataB[i*DATA_W +: DATA_W]  = h.b;
      end else begin
        reqOpCode[i*OP_W +: OP_W]     = OP_W'($urandom);
        reqDataA[i*DATA_W +: DATA_W]  = $urandom;
        reqDataB[i*DATA_W +: DATA_W]  = $urandom;
      end
    end
    reqValid = v;
    rspReady = ($urandom_range(0, 99) < rpct);
    eg = '0;
    gi = -1;
    if (m_free)
      for (int k = 0; k < N; k++)
        if (gi < 0 && v[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
    if (gi >= 0) eg[gi] = 1'b1;
    @(negedge clock);
    check("req_ready", 64'(reqReady), 64'(eg));
    check("rsp_valid", 64'(rspValid), 64'(!m_free && m_wait == 0));
    @(posedge clock);
    if (gi >= 0) begin
      h = pend[gi].pop_front();
      sb_q.push_back(ref_rsp(gi, h));
      ovf_knob = h.ovf;
      m_ptr    = (gi + 1) % N;
      m_free   = 1'b0;
      m_wait   = 1;
    end else if (!m_free) begin
      if (m_wait > 0) m_wait--;
      else if (rspReady) m_free = 1'b1;
    end
    #1;
  endtask

  task automatic run_until_done(input int budget);
    int c;
    c = 0;
    while (!(all_empty() && m_free && sb_q.size() == 0) && c < budget) begin
      step();
      c++;
    end
    reqValid = '0;
    check("drain_done", 64'(all_empty() && m_free && sb_q.size() == 0), 64'd1);
  endtask

  initial begin : monitor
    rsp_t          e;
    logic          pv, pc;
    logic [IW-1:0] pid;
    logic [31:0]   pdata;
    logic [2:0]    pflags;
    pv = 1'b0; pc = 1'b0; pid = '0; pdata = '0; pflags = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (rspValid && pv && !pc) begin
        check("stable_id", 64'(rspId), 64'(pid));
        check("stable_data", 64'(rspDataC), 64'(pdata));
        check("stable_flags", 64'({rspZero, rspOverflow, rspError}), 64'(pflags));
      end
      if (rspValid && rspReady) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %0h data %0h, expected no response", rspId, rspDataC);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id", 64'(rspId), 64'(e.id));
          check("rsp_data", 64'(rspDataC), 64'(e.data));
          check("rsp_zero", 64'(rspZero), 64'(e.zero));
          check("rsp_ovf", 64'(rspOverflow), 64'(e.ovf));
          check("rsp_err", 64'(rspError), 64'(e.err));
        end
      end
      pv     = rspValid;
      pc     = rspValid && rspReady;
      pid    = rspId;
      pdata  = rspDataC;
      pflags = {rspZero, rspOverflow, rspError};
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] a, b;
    n_tests  = 0;
    n_fail   = 0;
    m_ptr    = 0;
    m_free   = 1'b1;
    m_wait   = 0;
    vpct     = 100;
    rpct     = 100;
    ovf_knob = 1'b0;
    reqValid  = '1;
    reqOpCode = '1;
    reqDataA  = '1;
    reqDataB  = '1;
    rspReady  = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", 64'(reqReady), 64'd0);
    check("rst_rsp_valid", 64'(rspValid), 64'd0);
    check("rst_rsp_id", 64'(rspId), 64'd0);
    check("rst_rsp_data", 64'(rspDataC), 64'd0);
    check("rst_rsp_flags", 64'({rspZero, rspOverflow, rspError}), 64'd0);
    check("rst_alu_op", 64'(aluOpCode), 64'd0);
    check("rst_alu_a", 64'(aluDataA), 64'd0);
    check("rst_alu_b", 64'(aluDataB), 64'd0);
    reqValid = '0;
    reset    = 1'b0;
    @(posedge clock);
    #1;

    // Single ADD, then a lone req2 op so the pointer wraps back to requester 0.
    push(0, OP_ADD, 32'd5, 32'd7, 1'b0);
    run_until_done(20);
    push(2, OP_OR, 32'hF0, 32'h0F, 1'b0);
    run_until_done(20);

    for (int i = 0; i < 4; i++) begin
      push(0, OP_W'($urandom_range(0, 17)), $urandom, $urandom, 1'($urandom));
      push(1, OP_W'($urandom_range(0, 17)), $urandom, $urandom, 1'($urandom));
    end
    run_until_done(60);

    push(0, OP_DIV, 32'd100, 32'd0, 1'b1);
    push(0, OP_MOD, 32'd9, 32'd0, 1'b0);
    push(1, OP_SUB, 32'd3, 32'd3, 1'b1);
    push(2, OP_W'(20), 32'd44, 32'd2, 1'b1);
    push(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
    push(2, OP_AND, 32'd12, 32'd10, 1'b1);
    run_until_done(60);

    // Consumer stalls for well over ten cycles while req1 keeps asking.
    push(0, OP_XOR, 32'h1234, 32'h00FF, 1'b0);
    push(1, OP_SUB, 32'd10, 32'd4, 1'b0);
    rpct = 0;
    repeat (14) step();
    rpct = 100;
    run_until_done(40);

    // Reset while the accepted operation is executing.
    push(1, OP_ADD, 32'd10, 32'd20, 1'b0);
    step();
    reqValid = '1;
    reset    = 1'b1;
    #1;
    check("rst_exec_rsp_valid", 64'(rspValid), 64'd0);
    check("rst_exec_req_ready", 64'(reqReady), 64'd0);
    sb_q.delete();
    m_free = 1'b1;
    m_wait = 0;
    m_ptr  = 0;
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_exec_no_rsp", 64'(rspValid), 64'd0);
    reqValid = '0;
    reset    = 1'b0;
    @(posedge clock);
    #1;
    push(2, OP_SUB, 32'd50, 32'd8, 1'b0);
    push(1, OP_ADD, 32'd1, 32'd1, 1'b0);
    run_until_done(30);

    vpct = 70;
    rpct = 70;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      push($urandom_range(0, N - 1), OP_W'($urandom_range(0, 31)), a, b, 1'($urandom));
    end
    run_until_done(4000);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
